// File: rtl/lfu_comparador_if.sv
// Request/result bundle for the LFU victim comparator.
// Master drives the request (counters, way-valid bits); slave returns the registered victim choice.
interface lfu_comparador_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [3:0]       way_valid;
  logic [WIDTH-1:0] count0;
  logic [WIDTH-1:0] count1;
  logic [WIDTH-1:0] count2;
  logic [WIDTH-1:0] count3;
  logic [1:0]       cache_sel;
  logic [WIDTH-1:0] min_count;
  logic             out_valid;

  modport master (
    output in_valid, way_valid, count0, count1, count2, count3,
    input  cache_sel, min_count, out_valid
  );

  modport slave (
    input  in_valid, way_valid, count0, count1, count2, count3,
    output cache_sel, min_count, out_valid
  );
endinterface

// File: rtl/lfu_comparador.sv
// LFU victim select for a 4-way set: lowest-index invalid way, else lowest-index minimum counter.
// One-cycle registered latency, one compare per cycle, no backpressure.
module lfu_comparador #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  lfu_comparador_if.slave bus
);

  logic             lo_sel;
  logic [WIDTH-1:0] lo_min;
  logic             hi_sel;
  logic [WIDTH-1:0] hi_min;
  logic [1:0]       lfu_sel;
  logic [WIDTH-1:0] lfu_min;
  logic             any_invalid;
  logic [1:0]       inv_sel;
  logic [1:0]       nxt_sel;
  logic [WIDTH-1:0] nxt_min;

  logic [1:0]       sel_q;
  logic [WIDTH-1:0] min_q;
  logic             vld_q;

  // Two-level tree; each stage only moves right on a strict win, so ties keep the lower index.
  always_comb begin
    lo_sel = 1'b0;
    lo_min = bus.count0;
    if (bus.count1 < bus.count0) begin
      lo_sel = 1'b1;
      lo_min = bus.count1;
    end

    hi_sel = 1'b0;
    hi_min = bus.count2;
    if (bus.count3 < bus.count2) begin
      hi_sel = 1'b1;
      hi_min = bus.count3;
    end

    lfu_sel = {1'b0, lo_sel};
    lfu_min = lo_min;
    if (hi_min < lo_min) begin
      lfu_sel = {1'b1, hi_sel};
      lfu_min = hi_min;
    end
  end

  assign any_invalid = ~&bus.way_valid;

  always_comb begin
    inv_sel = 2'd3;
    if (!bus.way_valid[0])      inv_sel = 2'd0;
    else if (!bus.way_valid[1]) inv_sel = 2'd1;
    else if (!bus.way_valid[2]) inv_sel = 2'd2;
  end

  assign nxt_sel = any_invalid ? inv_sel : lfu_sel;
  assign nxt_min = any_invalid ? '0 : lfu_min;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 2'd0;
      min_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        sel_q <= nxt_sel;
        min_q <= nxt_min;
      end
    end
  end

  assign bus.cache_sel = sel_q;
  assign bus.min_count = min_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_lfu_comparador.sv
// Bench for lfu_comparador: directed vector table, reset/hold sequences, and random traffic vs a reference model.
module tb_lfu_comparador;

  logic clk;
  logic rst_n;

  lfu_comparador_if #(.WIDTH(4)) bus ();

  lfu_comparador #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] wv;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
    logic [3:0] c3;
    logic [1:0] sel;
    logic [3:0] mn;
  } vec_t;

  int n_cmp;
  int n_err;

  logic [1:0] exp_sel;
  logic [3:0] exp_min;
  logic       exp_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: first invalid way wins; otherwise find the minimum value, then its first occurrence.
  function automatic void ref_pick(input logic [3:0] wv, input logic [15:0] cv,
                                   output logic [1:0] s, output logic [3:0] m);
    logic [3:0] c [4];
    int mval;
    for (int i = 0; i < 4; i++) c[i] = cv[i*4 +: 4];
    for (int i = 3; i >= 0; i--) begin
      if (!wv[i]) begin
        s = 2'(i);
      end
    end
    if (wv != 4'hF) begin
      m = 4'd0;
      return;
    end
    mval = 99;
    for (int i = 0; i < 4; i++) if (int'(c[i]) < mval) mval = int'(c[i]);
    m = 4'(mval);
    for (int i = 3; i >= 0; i--) if (int'(c[i]) == mval) s = 2'(i);
  endfunction

  task automatic step(input logic v, input logic [3:0] wv,
                      input logic [3:0] c0, input logic [3:0] c1,
                      input logic [3:0] c2, input logic [3:0] c3);
    logic [1:0] s;
    logic [3:0] m;
    @(negedge clk);
    bus.in_valid  = v;
    bus.way_valid = wv;
    bus.count0    = c0;
    bus.count1    = c1;
    bus.count2    = c2;
    bus.count3    = c3;
    @(posedge clk);
    if (v) begin
      ref_pick(wv, {c3, c2, c1, c0}, s, m);
      exp_sel = s;
      exp_min = m;
    end
    exp_vld = v;
    #1;
    chk("model_sel", 32'(bus.cache_sel), 32'(exp_sel));
    chk("model_min", 32'(bus.min_count), 32'(exp_min));
    chk("model_vld", 32'(bus.out_valid), 32'(exp_vld));
  endtask

  vec_t tv [16];

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_sel = 2'd0;
    exp_min = 4'd0;
    exp_vld = 1'b0;
    rst_n = 1'b1;
    bus.in_valid  = 1'b0;
    bus.way_valid = 4'hF;
    bus.count0 = 4'd0;
    bus.count1 = 4'd0;
    bus.count2 = 4'd0;
    bus.count3 = 4'd0;

    //            wv     c0     c1     c2     c3     sel   min
    tv[0]  = '{4'hF, 4'd0,  4'd0,  4'd0,  4'd0,  2'd0, 4'd0};
    tv[1]  = '{4'hF, 4'd7,  4'd7,  4'd7,  4'd7,  2'd0, 4'd7};
    tv[2]  = '{4'hF, 4'd0,  4'd0,  4'd0,  4'd2,  2'd0, 4'd0};
    tv[3]  = '{4'hF, 4'd0,  4'd3,  4'd3,  4'd0,  2'd0, 4'd0};
    tv[4]  = '{4'hF, 4'd4,  4'd2,  4'd3,  4'd4,  2'd1, 4'd2};
    tv[5]  = '{4'hF, 4'd5,  4'd2,  4'd2,  4'd2,  2'd1, 4'd2};
    tv[6]  = '{4'hF, 4'd9,  4'd1,  4'd2,  4'd3,  2'd1, 4'd1};
    tv[7]  = '{4'hF, 4'd4,  4'd5,  4'd2,  4'd3,  2'd2, 4'd2};
    tv[8]  = '{4'hF, 4'd8,  4'd7,  4'd9,  4'd6,  2'd3, 4'd6};
    tv[9]  = '{4'hF, 4'd0,  4'd10, 4'd2,  4'd3,  2'd0, 4'd0};
    tv[10] = '{4'hF, 4'd15, 4'd15, 4'd15, 4'd14, 2'd3, 4'd14};
    tv[11] = '{4'hF, 4'd15, 4'd0,  4'd15, 4'd15, 2'd1, 4'd0};
    tv[12] = '{4'hB, 4'd0,  4'd0,  4'd9,  4'd0,  2'd2, 4'd0};
    tv[13] = '{4'h6, 4'd1,  4'd2,  4'd3,  4'd4,  2'd0, 4'd0};
    tv[14] = '{4'h7, 4'd5,  4'd6,  4'd7,  4'd1,  2'd3, 4'd0};
    tv[15] = '{4'hD, 4'd9,  4'd3,  4'd0,  4'd0,  2'd1, 4'd0};

    // Asynchronous reset between edges must clear outputs immediately.
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(bus.cache_sel), 32'd0);
    chk("rst_min", 32'(bus.min_count), 32'd0);
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'hF, 4'd3, 4'd2, 4'd1, 4'd0);
    step(1'b0, 4'hF, 4'd3, 4'd2, 4'd1, 4'd0);

    // Directed table, back-to-back with in_valid held high.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tv[i].wv, tv[i].c0, tv[i].c1, tv[i].c2, tv[i].c3);
      chk($sformatf("tbl%0d_sel", i), 32'(bus.cache_sel), 32'(tv[i].sel));
      chk($sformatf("tbl%0d_min", i), 32'(bus.min_count), 32'(tv[i].mn));
      chk($sformatf("tbl%0d_vld", i), 32'(bus.out_valid), 32'd1);
    end

    // Hold: one request, then idle with changing counters.
    step(1'b1, 4'hF, 4'd8, 4'd7, 4'd9, 4'd6);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3));
      chk("hold_sel", 32'(bus.cache_sel), 32'd3);
      chk("hold_min", 32'(bus.min_count), 32'd6);
      chk("hold_vld", 32'(bus.out_valid), 32'd0);
    end

    // Reset in the cycle after a request edge discards the result.
    step(1'b1, 4'hF, 4'd9, 4'd1, 4'd2, 4'd3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_sel = 2'd0;
    exp_min = 4'd0;
    exp_vld = 1'b0;
    #1;
    chk("midrst_sel", 32'(bus.cache_sel), 32'd0);
    chk("midrst_min", 32'(bus.min_count), 32'd0);
    chk("midrst_vld", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_vld_after", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release is a normal sampling edge.
    step(1'b1, 4'hF, 4'd4, 4'd5, 4'd2, 4'd3);
    chk("post_rst_sel", 32'(bus.cache_sel), 32'd2);

    // Random traffic; narrow counter range half the time to provoke ties.
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [3:0] wv;
      logic [3:0] c [4];
      int         rng;
      v   = ($urandom_range(0, 3) != 0);
      wv  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      rng = ($urandom_range(0, 1) == 0) ? 3 : 15;
      for (int k = 0; k < 4; k++) c[k] = 4'($urandom_range(0, rng));
      step(v, wv, c[0], c[1], c[2], c[3]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
